// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises and filters the raw lines, frames and parity-checks
// each byte, and folds E0/F0 prefixes into flags so one pulse is emitted per key event.
module ps2_key_receiver #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clock,
   input  logic       ps2_data,
   output logic       ps2_key_pressed,
   output logic [7:0] ps2_out,
   output logic       ps2_break,
   output logic       ps2_extended,
   output logic       frame_error
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

   logic [1:0] clk_sync_q;
   logic [1:0] dat_sync_q;
   logic       clk_s;
   logic       dat_s;

   // NOTE: sequential state always uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, exactly like the hardware shift chain.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clock};
         dat_sync_q <= {dat_sync_q[0], ps2_data};
      end
   end

   assign clk_s = clk_sync_q[1];
   assign dat_s = dat_sync_q[1];

   logic          filt_q, filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall_edge;

   // NOTE: every signal written here gets a default first, otherwise paths that skip an
   // assignment would infer a latch.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      fall_edge  = 1'b0;
      if (clk_s != filt_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            filt_d    = ~filt_q;
            fall_edge = filt_q;
         end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
      end
   end

   state_e        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_ok_q, par_ok_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          ext_pend_q, ext_pend_d;
   logic          brk_pend_q, brk_pend_d;
   logic          key_q, key_d;
   logic          err_q, err_d;
   logic [7:0]    out_q, out_d;
   logic          brk_q, brk_d;
   logic          ext_q, ext_d;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_ok_d   = par_ok_q;
      ext_pend_d = ext_pend_q;
      brk_pend_d = brk_pend_q;
      key_d      = 1'b0;
      err_d      = 1'b0;
      out_d      = out_q;
      brk_d      = brk_q;
      ext_d      = ext_q;

      if (state_q == S_IDLE || fall_edge) begin
         to_cnt_d = '0;
      end else begin
         to_cnt_d = to_cnt_q + TW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (fall_edge && !dat_s) begin
               bit_cnt_d = 3'd0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (fall_edge) begin
               shift_d   = {dat_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (fall_edge) begin
               par_ok_d = ^{shift_q, dat_s};
               state_d  = S_STOP;
            end
         end
         S_STOP: begin
            if (fall_edge) begin
               state_d = S_IDLE;
               if (par_ok_q && dat_s) begin
                  if (shift_q == 8'hE0) begin
                     ext_pend_d = 1'b1;
                  end else if (shift_q == 8'hF0) begin
                     brk_pend_d = 1'b1;
                  end else begin
                     key_d      = 1'b1;
                     out_d      = shift_q;
                     brk_d      = brk_pend_q;
                     ext_d      = ext_pend_q;
                     ext_pend_d = 1'b0;
                     brk_pend_d = 1'b0;
                  end
               end else begin
                  err_d      = 1'b1;
                  ext_pend_d = 1'b0;
                  brk_pend_d = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Counter would reach TIMEOUT_CYCLES on this edge: abandon the frame.
      if (state_q != S_IDLE && !fall_edge && to_cnt_q == TO_LAST) begin
         state_d    = S_IDLE;
         to_cnt_d   = '0;
         err_d      = 1'b1;
         ext_pend_d = 1'b0;
         brk_pend_d = 1'b0;
      end
   end

   // NOTE: only control and output flops need reset; the shift register and parity latch
   // are reset too here because they are tiny and it keeps simulation X-free.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         par_ok_q   <= 1'b0;
         to_cnt_q   <= '0;
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         key_q      <= 1'b0;
         err_q      <= 1'b0;
         out_q      <= 8'h00;
         brk_q      <= 1'b0;
         ext_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_ok_q   <= par_ok_d;
         to_cnt_q   <= to_cnt_d;
         ext_pend_q <= ext_pend_d;
         brk_pend_q <= brk_pend_d;
         key_q      <= key_d;
         err_q      <= err_d;
         out_q      <= out_d;
         brk_q      <= brk_d;
         ext_q      <= ext_d;
      end
   end

   assign ps2_key_pressed = key_q;
   assign frame_error     = err_q;
   assign ps2_out         = out_q;
   assign ps2_break       = brk_q;
   assign ps2_extended    = ext_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: directed frame table, timeout/glitch/reset sequences and
// randomized frames checked against a key-event level model.
module tb_ps2_key_receiver;

   localparam int unsigned FILTER_LEN     = 8;
   localparam int unsigned TIMEOUT_CYCLES = 5000;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clock = 1'b1;
   logic       ps2_data = 1'b1;
   logic       ps2_key_pressed;
   logic [7:0] ps2_out;
   logic       ps2_break;
   logic       ps2_extended;
   logic       frame_error;

   ps2_key_receiver #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ps2_clock      (ps2_clock),
      .ps2_data       (ps2_data),
      .ps2_key_pressed(ps2_key_pressed),
      .ps2_out        (ps2_out),
      .ps2_break      (ps2_break),
      .ps2_extended   (ps2_extended),
      .frame_error    (frame_error)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int fall_cyc = 0;
   int key_cnt  = 0;
   int err_cnt  = 0;
   int both_cnt = 0;
   int key_lat  = 0;
   int err_lat  = 0;

   // Reference model state: what the consumer should see after each event.
   logic [7:0] m_out;
   bit         m_brk, m_ext, m_pe, m_pb;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (reset) begin
         if (ps2_key_pressed) begin
            key_cnt = key_cnt + 1;
            key_lat = cyc - fall_cyc;
         end
         if (frame_error) begin
            err_cnt = err_cnt + 1;
            err_lat = cyc - fall_cyc;
         end
         if (ps2_key_pressed && frame_error) both_cnt = both_cnt + 1;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int half);
      @(negedge clock);
      ps2_data = b;
      repeat (half) @(negedge clock);
      ps2_clock = 1'b0;
      fall_cyc  = cyc;
      repeat (half) @(negedge clock);
      ps2_clock = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop, input int half);
      send_bit(1'b0, half);
      for (int i = 0; i < 8; i++) send_bit(d[i], half);
      send_bit(~(^d) ^ flip, half);
      send_bit(stop, half);
      @(negedge clock);
      ps2_data = 1'b1;
   endtask

   task automatic model_frame(input logic [7:0] d, input bit good, output int ek, output int ee);
      ek = 0;
      ee = 0;
      if (!good) begin
         ee   = 1;
         m_pe = 1'b0;
         m_pb = 1'b0;
      end else if (d == 8'hE0) begin
         m_pe = 1'b1;
      end else if (d == 8'hF0) begin
         m_pb = 1'b1;
      end else begin
         ek    = 1;
         m_out = d;
         m_brk = m_pb;
         m_ext = m_pe;
         m_pe  = 1'b0;
         m_pb  = 1'b0;
      end
   endtask

   task automatic run_frame(input string name, input logic [7:0] d, input bit flip, input bit stop,
                            input int half, input int ek, input int ee,
                            input logic [7:0] eo, input bit eb, input bit ex);
      int k0, e0, b0;
      k0 = key_cnt;
      e0 = err_cnt;
      b0 = both_cnt;
      send_frame(d, flip, stop, half);
      repeat (40) @(negedge clock);
      check({name, ".key_pulses"}, key_cnt - k0, ek);
      check({name, ".err_pulses"}, err_cnt - e0, ee);
      check({name, ".ps2_out"}, ps2_out, eo);
      check({name, ".ps2_break"}, ps2_break, eb);
      check({name, ".ps2_extended"}, ps2_extended, ex);
      check({name, ".pulse_overlap"}, both_cnt - b0, 0);
      if (ek != 0)
         check({name, ".latency_in_window"},
               (key_lat >= FILTER_LEN + 2 && key_lat <= FILTER_LEN + 3), 1);
   endtask

   // Model-driven frame: expectation comes from the reference model.
   task automatic model_run(input string name, input logic [7:0] d, input bit flip, input bit stop,
                            input int half);
      int ek, ee;
      model_frame(d, !flip && stop, ek, ee);
      run_frame(name, d, flip, stop, half, ek, ee, m_out, m_brk, m_ext);
   endtask

   typedef struct {
      logic [7:0] data;
      bit         par_flip;
      bit         stop;
      int         exp_key;
      int         exp_err;
      logic [7:0] exp_out;
      bit         exp_brk;
      bit         exp_ext;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int ek, ee, e0, k0;
      logic [7:0] d;
      bit flip, stop;

      vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};
      vecs[1]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
      vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b1, 1'b0};
      vecs[3]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b1, 1'b0};
      vecs[4]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b1, 1'b0};
      vecs[5]  = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 1'b1, 1'b1};
      vecs[6]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};
      vecs[7]  = '{8'h29, 1'b0, 1'b1, 1, 0, 8'h29, 1'b0, 1'b0};
      vecs[8]  = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h29, 1'b0, 1'b0};
      vecs[9]  = '{8'h1C, 1'b0, 1'b0, 0, 1, 8'h29, 1'b0, 1'b0};
      vecs[10] = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h29, 1'b0, 1'b0};
      vecs[11] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h29, 1'b0, 1'b0};
      vecs[12] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};

      m_out = 8'h00; m_brk = 1'b0; m_ext = 1'b0; m_pe = 1'b0; m_pb = 1'b0;

      repeat (5) @(negedge clock);
      check("reset.ps2_out", ps2_out, 8'h00);
      check("reset.ps2_break", ps2_break, 0);
      check("reset.ps2_extended", ps2_extended, 0);
      check("reset.key_pressed", ps2_key_pressed, 0);
      check("reset.frame_error", frame_error, 0);
      reset = 1'b1;
      repeat (5) @(negedge clock);

      for (int i = 0; i < 13; i++) begin
         model_frame(vecs[i].data, !vecs[i].par_flip && vecs[i].stop, ek, ee);
         run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par_flip, vecs[i].stop, 12,
                   vecs[i].exp_key, vecs[i].exp_err, vecs[i].exp_out, vecs[i].exp_brk,
                   vecs[i].exp_ext);
      end

      // Timeout: pending F0, then start + 4 data bits and the clock left high.
      model_run("to_prefix", 8'hF0, 1'b0, 1'b1, 12);
      e0 = err_cnt;
      k0 = key_cnt;
      send_bit(1'b0, 12);
      send_bit(1'b1, 12);
      send_bit(1'b0, 12);
      send_bit(1'b0, 12);
      send_bit(1'b1, 12);
      for (int i = 0; i < int'(TIMEOUT_CYCLES) + 200 && err_cnt == e0; i++) @(negedge clock);
      check("timeout.err_pulses", err_cnt - e0, 1);
      check("timeout.key_pulses", key_cnt - k0, 0);
      check("timeout.delay", err_lat, key_lat + int'(TIMEOUT_CYCLES));
      m_pe = 1'b0;
      m_pb = 1'b0;
      repeat (20) @(negedge clock);
      model_run("after_timeout", 8'h29, 1'b0, 1'b1, 12);

      // Short low glitch with data low: must not be taken as a start bit.
      k0 = key_cnt;
      e0 = err_cnt;
      @(negedge clock);
      ps2_data  = 1'b0;
      ps2_clock = 1'b0;
      repeat (FILTER_LEN - 1) @(negedge clock);
      ps2_clock = 1'b1;
      ps2_data  = 1'b1;
      repeat (30) @(negedge clock);
      check("glitch.key_pulses", key_cnt - k0, 0);
      check("glitch.err_pulses", err_cnt - e0, 0);
      model_run("after_glitch", 8'h1C, 1'b0, 1'b1, 12);

      // Reset mid-frame with a pending F0.
      model_run("rst_prefix", 8'hF0, 1'b0, 1'b1, 12);
      send_bit(1'b0, 12);
      send_bit(1'b1, 12);
      send_bit(1'b0, 12);
      @(negedge clock);
      ps2_data = 1'b1;
      reset    = 1'b0;
      repeat (3) @(negedge clock);
      check("midreset.ps2_out", ps2_out, 8'h00);
      check("midreset.ps2_break", ps2_break, 0);
      check("midreset.ps2_extended", ps2_extended, 0);
      check("midreset.key_pressed", ps2_key_pressed, 0);
      check("midreset.frame_error", frame_error, 0);
      reset = 1'b1;
      m_out = 8'h00; m_brk = 1'b0; m_ext = 1'b0; m_pe = 1'b0; m_pb = 1'b0;
      repeat (10) @(negedge clock);
      model_run("after_reset", 8'h5A, 1'b0, 1'b1, 12);

      // Randomized frames with prefixes and occasional corruption.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       d = 8'hE0;
            1:       d = 8'hF0;
            default: d = 8'($urandom_range(0, 255));
         endcase
         flip = 1'b0;
         stop = 1'b1;
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) flip = 1'b1;
            else stop = 1'b0;
         end
         model_run($sformatf("rand%0d", i), d, flip, stop, int'($urandom_range(10, 18)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
